// File: rtl/mpt_parsing_stage_if.sv
// Purpose: generic valid/ready/data channel used for the stage input and both stage outputs.
// Latency: none, this is only a bundle of wires.
// Backpressure: a transfer happens on a rising edge when valid and ready are both 1.
interface mpt_parsing_stage_if #(
   parameter int W = 8
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mpt_parsing_stage.sv
// Purpose: decode one fetched MPT entry into a leaf/fault verdict or a next-level walk request.
// Latency: 1 cycle from input handshake to output valid; one output register shared by both masters.
// Backpressure: input ready = register empty or addressed master ready; output held stable while stalled.
module mpt_parsing_stage #(
   parameter int  ADDR_WIDTH   = 64,
   parameter int  ENTRY_WIDTH  = 64,
   parameter int  ID_WIDTH     = 4,
   localparam int SLAVE_WIDTH  = ID_WIDTH + 2 + 2 + ADDR_WIDTH + ENTRY_WIDTH,
   localparam int WALK_WIDTH   = ID_WIDTH + 2 + 2 + 2 * ADDR_WIDTH,
   localparam int RESULT_WIDTH = ID_WIDTH + ADDR_WIDTH + 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mpt_parsing_stage_if.slave  stage_slave,
   mpt_parsing_stage_if.master walk_master,
   mpt_parsing_stage_if.master result_master,
   output logic [15:0]         fault_count_o
);

   localparam int OFF_PA  = ENTRY_WIDTH;
   localparam int OFF_LVL = ENTRY_WIDTH + ADDR_WIDTH;
   localparam int OFF_ACC = OFF_LVL + 2;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_dest_res;   // 1: item goes to result master, 0: walk master
   logic [WALK_WIDTH-1:0]   r_walk_dat;
   logic [RESULT_WIDTH-1:0] r_res_dat;
   logic [15:0]             r_fault_cnt;

   logic [ID_WIDTH-1:0]     w_id;
   logic [1:0]              w_access;
   logic [1:0]              w_level;
   logic [1:0]              w_level_nxt;
   logic [ADDR_WIDTH-1:0]   w_paddr;
   logic [ADDR_WIDTH-1:0]   w_entry_addr;
   logic                    w_v;
   logic                    w_l;
   logic [2:0]              w_perm;       // {X, W, R}
   logic [4:0]              w_rsvd;
   logic [43:0]             w_ppn;
   logic [8:0]              w_idx;
   logic                    w_fault;
   logic                    w_allow;
   logic                    w_is_walk;
   logic                    w_unused_bits;
   logic                    w_out_vld;
   logic                    w_out_rdy;
   logic                    w_in_hs;
   logic                    w_out_hs;
   logic                    w_load;

   // Field extraction from the packed input word.
   assign w_id          = stage_slave.data[SLAVE_WIDTH-1 -: ID_WIDTH];
   assign w_access      = stage_slave.data[OFF_ACC +: 2];
   assign w_level       = stage_slave.data[OFF_LVL +: 2];
   assign w_paddr       = stage_slave.data[OFF_PA +: ADDR_WIDTH];
   assign w_v           = stage_slave.data[0];
   assign w_l           = stage_slave.data[1];
   assign w_perm        = stage_slave.data[4:2];
   assign w_rsvd        = stage_slave.data[9:5];
   assign w_ppn         = stage_slave.data[53:10];
   assign w_unused_bits = ^stage_slave.data[ENTRY_WIDTH-1:54];

   // Child table pointer: PPN page base plus 8-byte slot selected by the next level's VPN slice.
   assign w_level_nxt  = w_level - 2'd1;
   assign w_idx        = 9'(w_paddr >> (12 + 9 * int'(w_level_nxt)));
   assign w_entry_addr = ADDR_WIDTH'({w_ppn, 12'b0}) + ADDR_WIDTH'({w_idx, 3'b000});

   // Entry decode in priority order: faults first, then leaf, otherwise descend.
   always_comb begin
      w_fault   = 1'b0;
      w_allow   = 1'b0;
      w_is_walk = 1'b0;
      if (!w_v || (w_rsvd != 5'd0) || (w_access == 2'd3) || (!w_l && (w_level == 2'd0))) begin
         w_fault = 1'b1;
      end else if (w_l) begin
         case (w_access)
            2'd0:    w_allow = w_perm[0];
            2'd1:    w_allow = w_perm[1] & w_perm[0];   // write-only encodings never grant write
            default: w_allow = w_perm[2];
         endcase
      end else begin
         w_is_walk = 1'b1;
      end
   end

   // Handshake plumbing; only the master named by the destination flag sees valid.
   assign w_out_vld           = (r_state == ST_FULL);
   assign w_out_rdy           = r_dest_res ? result_master.ready : walk_master.ready;
   assign stage_slave.ready   = ~w_out_vld | w_out_rdy;
   assign w_in_hs             = stage_slave.valid & stage_slave.ready;
   assign w_out_hs            = w_out_vld & w_out_rdy;
   assign walk_master.valid   = w_out_vld & ~r_dest_res;
   assign result_master.valid = w_out_vld & r_dest_res;
   assign walk_master.data    = r_walk_dat;
   assign result_master.data  = r_res_dat;
   assign fault_count_o       = r_fault_cnt;

   // Occupancy next-state: fill on accept, empty on drain without refill.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = w_in_hs;
      case (r_state)
         ST_EMPTY: if (w_in_hs) w_state_nxt = ST_FULL;
         ST_FULL:  if (w_out_hs && !w_in_hs) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // Occupancy register; reset drops any in-flight item.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Output payload register, loaded on every accepted input (no reset needed).
   always_ff @(posedge clk_i) begin
      if (w_load) begin
         r_dest_res <= ~w_is_walk;
         r_walk_dat <= {w_id, w_access, w_level_nxt, w_paddr, w_entry_addr};
         r_res_dat  <= {w_id, w_paddr, w_fault, w_allow};
      end
   end

   // Saturating count of faulted verdicts actually handed to the consumer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fault_cnt <= 16'd0;
      end else if (result_master.valid && result_master.ready && r_res_dat[1] &&
                   (r_fault_cnt != 16'hFFFF)) begin
         r_fault_cnt <= r_fault_cnt + 16'd1;
      end
   end

endmodule
